// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU
// in the execute stage. An operation is accepted with a valid/ready handshake.
// The unit then spends 32 radix-2 steps in CALC and one more edge applying
// sign correction. The result is held in DONE until the consumer takes it.
// Divide-by-zero and signed overflow skip CALC and finish one edge after
// accept.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any in-flight or pending operation
//   in_valid   operands and md_op are valid
//   in_ready   unit is idle and can accept an operation
//   md_op      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   A, B       rs1 / rs2 operands, two's complement
//   out_valid  result is valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out        result
//   busy       operation in flight or result pending
// ----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   output logic            busy
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                r_state;
   logic [2:0]            r_op;
   logic                  r_sA;
   logic                  r_sB;
   logic [XLEN-1:0]       r_opA;
   logic [XLEN-1:0]       r_opB;
   logic [2*XLEN-1:0]     r_prod;
   logic [CNT_W-1:0]      r_cnt;
   logic [XLEN-1:0]       r_out;

   logic                  w_aSigned;
   logic                  w_bSigned;
   logic                  w_sA;
   logic                  w_sB;
   logic [XLEN-1:0]       w_magA;
   logic [XLEN-1:0]       w_magB;
   logic                  w_divZero;
   logic                  w_divOvf;
   logic                  w_special;
   logic [XLEN-1:0]       w_specRes;

   logic [XLEN:0]         w_mulSum;
   logic [XLEN:0]         w_divHi;
   logic [XLEN-1:0]       w_divDiff;
   logic                  w_divGe;
   logic [2*XLEN-1:0]     w_stepNext;

   logic [2*XLEN-1:0]     w_prodFix;
   logic [XLEN-1:0]       w_quot;
   logic [XLEN-1:0]       w_rem;
   logic [XLEN-1:0]       w_final;

   // Handshake and status flags come straight from the state register, so
   // they are glitch-free and change only on a clock edge or reset.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign out       = r_out;

   // Operand decode at the accept edge. Only signed operands are converted
   // to magnitudes; the sign of an unsigned operand is forced to zero so the
   // later sign-correction logic is the same for every op. Negating 0x8000_0000
   // wraps back to 0x8000_0000, which is the correct unsigned magnitude.
   always_comb begin
      w_aSigned = (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                  (md_op == OP_DIV)  || (md_op == OP_REM);
      w_bSigned = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
      w_sA      = w_aSigned & A[XLEN-1];
      w_sB      = w_bSigned & B[XLEN-1];
      w_magA    = w_sA ? (~A + 1'b1) : A;
      w_magB    = w_sB ? (~B + 1'b1) : B;

      // Division corner cases finish without iterating. md_op[1] separates
      // the remainder ops from the quotient ops.
      w_divZero = md_op[2] && (B == '0);
      w_divOvf  = ((md_op == OP_DIV) || (md_op == OP_REM)) &&
                  (A == MIN_NEG) && (B == '1);
      w_special = w_divZero | w_divOvf;
      if (w_divZero) begin
         w_specRes = md_op[1] ? A : '1;
      end else begin
         w_specRes = md_op[1] ? '0 : MIN_NEG;
      end
   end

   // One radix-2 step. r_prod is shared by both operations.
   //  - Multiply: the upper half accumulates and the lower half holds the
   //    remaining multiplier bits. Each step conditionally adds the
   //    multiplicand to the upper half and shifts the whole register right.
   //  - Divide: {remainder, dividend/quotient} shifts left. The quotient bit
   //    enters at the bottom when the shifted remainder covers the divisor.
   //    The remainder is always below the divisor, so a 32-bit subtraction
   //    result is enough.
   always_comb begin
      w_mulSum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                  (r_prod[0] ? {1'b0, r_opA} : {(XLEN+1){1'b0}});
      w_divHi   = r_prod[2*XLEN-1:XLEN-1];
      w_divGe   = (w_divHi >= {1'b0, r_opB});
      w_divDiff = w_divHi[XLEN-1:0] - r_opB;
      if (r_op[2]) begin
         if (w_divGe) begin
            w_stepNext = {w_divDiff, r_prod[XLEN-2:0], 1'b1};
         end else begin
            w_stepNext = {w_divHi[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
         end
      end else begin
         w_stepNext = {w_mulSum, r_prod[XLEN-1:1]};
      end
   end

   // Sign correction and result selection once the iterations are complete.
   // Unsigned operands carry a zero sign, so MUL/MULHU/DIVU/REMU never
   // negate. MULHSU negates on sA alone because sB is zero for it.
   always_comb begin
      w_prodFix = (r_sA ^ r_sB) ? (~r_prod + 1'b1) : r_prod;
      w_quot    = (r_sA ^ r_sB) ? (~r_prod[XLEN-1:0] + 1'b1) : r_prod[XLEN-1:0];
      w_rem     = r_sA ? (~r_prod[2*XLEN-1:XLEN] + 1'b1) : r_prod[2*XLEN-1:XLEN];
      case (r_op)
         OP_MUL:                      w_final = w_prodFix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prodFix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             w_final = w_quot;
         default:                     w_final = w_rem;
      endcase
   end

   // Control FSM and datapath registers. flush wins over everything else
   // and drops any pending result. CALC runs 32 step edges while the counter
   // goes from 0 to 32. The next edge loads the corrected result and enters
   // DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_sA    <= 1'b0;
         r_sB    <= 1'b0;
         r_opA   <= '0;
         r_opB   <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
      end else if (flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op   <= md_op;
                  r_sA   <= w_sA;
                  r_sB   <= w_sB;
                  r_opA  <= w_magA;
                  r_opB  <= w_magB;
                  r_prod <= md_op[2] ? {{XLEN{1'b0}}, w_magA} : {{XLEN{1'b0}}, w_magB};
                  r_cnt  <= '0;
                  if (w_special) begin
                     r_out   <= w_specRes;
                     r_state <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (r_cnt == LAST_CNT) begin
                  r_out   <= w_final;
                  r_state <= DONE;
               end else begin
                  r_prod <= w_stepNext;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
